// File: rtl/piso_tx_if.sv
// Handshake and serial-side signals of the parallel-in / serial-out transmitter.
// The master drives the word and the downstream shift permission. The slave
// (piso_tx) returns the handshake and the serial stream.
interface piso_tx_if #(
    parameter int N = 4
);
    logic [N-1:0] data_in;
    logic         in_valid;
    logic         in_ready;
    logic         shift_en;
    logic         serial_out;
    logic         serial_valid;
    logic         done;
    logic         busy;

    modport master (
        output data_in, in_valid, shift_en,
        input  in_ready, serial_out, serial_valid, done, busy
    );

    modport slave (
        input  data_in, in_valid, shift_en,
        output in_ready, serial_out, serial_valid, done, busy
    );
endinterface

// File: rtl/piso_tx.sv
// Parallel-in / serial-out transmitter. Words are sent LSB first, one bit per
// cycle in which shift_en is high. A new word can be accepted on the edge that
// retires the last bit of the current one, so streams have no idle gap.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no word held; in_ready=1, serial outputs quiet
// SHIFT | word held in shreg; shreg[0] is the bit on serial_out, cnt is
//       | the index of that bit within the word (0..N-1)
module piso_tx #(
    parameter int N = 4
) (
    input  logic      clk,
    input  logic      rst,
    piso_tx_if.slave  bus
);
    localparam int            CW   = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   shreg_q, shreg_d;
    logic [CW-1:0]  cnt_q,   cnt_d;

    logic           in_shift;
    logic           at_last;
    logic           accept;

    // Handshake and serial outputs are pure decodes of the held state and shift_en.
    always_comb begin
        in_shift         = (state_q == SHIFT);
        at_last          = in_shift && bus.shift_en && (cnt_q == LAST);
        bus.in_ready     = !in_shift || at_last;
        accept           = bus.in_valid && bus.in_ready;
        bus.serial_out   = in_shift ? shreg_q[0] : 1'b0;
        bus.serial_valid = in_shift && bus.shift_en;
        bus.done         = at_last;
        bus.busy         = in_shift;
    end

    // Next-state: load on accept (also chains off the last bit), else shift or hold.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        if (accept) begin
            state_d = SHIFT;
            shreg_d = bus.data_in;
            cnt_d   = '0;
        end else if (in_shift && bus.shift_en) begin
            if (cnt_q == LAST) begin
                // Last bit leaves with nothing queued behind it.
                state_d = IDLE;
            end else begin
                shreg_d = {1'b0, shreg_q[N-1:1]};
                cnt_d   = cnt_q + 1'b1;
            end
        end
    end

    // State registers; reset clears any partially sent word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: doc/piso_tx.md
PISO_TX -- requirements
Module: piso_tx

Interface
REQ-001 The block SHALL have parameter: N, default 4, parallel word width in bits (legal N >= 2).
REQ-002 The block SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 The block SHALL have port: rst  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have port: data_in  input  N  parallel word to serialize.
REQ-005 The block SHALL have port: in_valid  input  1  data_in holds a word offered for transfer.
REQ-006 The block SHALL have port: in_ready  output  1  block accepts data_in at this edge if in_valid=1.
REQ-007 The block SHALL have port: shift_en  input  1  downstream allows a bit this cycle; 0 = stall.
REQ-008 The block SHALL have port: serial_out  output  1  current serial bit, LSB-first.
REQ-009 The block SHALL have port: serial_valid  output  1  serial_out is a valid bit this cycle; drives the receiver's load/shift enable.
REQ-010 The block SHALL have port: done  output  1  last bit of the current word is presented this cycle.
REQ-011 The block SHALL have port: busy  output  1  a word is held and not fully sent (state SHIFT).

Function
REQ-012 The block SHALL implement a two-state FSM: IDLE, SHIFT; internal N-bit shift register shreg and ceil(log2(N))-bit bit counter cnt.
REQ-013 The handshake SHALL occur at a rising edge where in_valid=1 and in_ready=1; data_in loads into shreg, cnt<=0, state<=SHIFT.
REQ-014 in_ready SHALL be combinational: 1 in IDLE; 1 in SHIFT only when cnt=N-1 and shift_en=1; else 0.
REQ-015 The transmitter SHALL drive serial_out = shreg[0] in SHIFT and 0 in IDLE.
REQ-016 serial_valid SHALL be (state=SHIFT) and shift_en; it is combinational and has no extra latency.
REQ-017 At an edge in SHIFT with shift_en=1 and cnt<N-1, the block SHALL shift shreg right by one (MSB filled with 0) and increment cnt.
REQ-018 At an edge in SHIFT with shift_en=0, shreg, cnt and state SHALL hold; serial_out SHALL remain stable.
REQ-019 done SHALL be (state=SHIFT) and shift_en and cnt=N-1, giving exactly one done cycle per word.
REQ-020 At an edge with done=1: if in_valid=1, the new word SHALL load with cnt<=0 and the block SHALL stay in SHIFT, with no idle gap between words; otherwise the block SHALL go to IDLE.
REQ-021 Latency SHALL be: first bit valid in the cycle after acceptance; a word occupies exactly N serial_valid cycles plus any stall cycles.
REQ-022 Bit order SHALL be data_in[0] first and data_in[N-1] last, so that a right-shifting SIPO that inserts at its MSB reconstructs data_in after N loads.
REQ-023 in_valid while busy and not at the last bit SHALL be ignored, with no capture and no state change; the word stays pending at the source.
REQ-024 data_in changes after acceptance SHALL NOT affect the word in flight.
REQ-025 For N not a power of two, cnt SHALL never exceed N-1.

Reset
REQ-026 While rst=0, regardless of clk, the block SHALL set: state=IDLE, shreg=0, cnt=0; serial_out=0, serial_valid=0, done=0, busy=0, in_ready=1.
REQ-027 Reset asserted mid-word SHALL discard the partial word; the first edge after release with in_valid=1 starts a fresh word.
REQ-028 There SHALL be no synchronous reset and no other initialization path.

Verification
REQ-029 N=4, shift_en=1, accept 4'b1011 -> serial_out 1,1,0,1 on 4 consecutive serial_valid cycles, done on 4th; chained SIPO (load=serial_valid) parallel_out=4'b1011.
REQ-030 4'b0110, shift_en=0 for 2 cycles after bit 1 -> serial_out held at 1, serial_valid=0 during stall, done 2 cycles later than unstalled; received word 4'b0110.
REQ-031 in_valid held with 4'hA then 4'h5 -> 8 consecutive serial_valid cycles, bits 0,1,0,1,1,0,1,0; in_ready=1 only at each done cycle; busy never drops.
REQ-032 in_valid=1 with 4'hF during bit 1 of a word -> in_ready=0, no capture; 4'hF accepted at the done edge and sent next.
REQ-033 shift_en=0 on the last bit with in_valid=1 -> in_ready=0, done=0; acceptance occurs at the first edge with shift_en=1.
REQ-034 rst pulled low asynchronously after 2 bits of 4'b1001 -> outputs go to reset values immediately; after release, 4'b0011 sends 1,1,0,0 cleanly.
